// File: rtl/btb_assoc_pkg.sv
// Shared types and defaults for the set-associative branch target buffer.
// The counter-training helper is kept here so every user saturates the same way.
package btb_assoc_pkg;

    localparam int XLEN     = 32;
    localparam int BTB_SETS = 64;
    localparam int BTB_WAYS = 2;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JAL  = 2'd1,
        BR_JALR = 2'd2,
        BR_RET  = 2'd3
    } btb_br_type_e;

    // 2-bit saturating direction counter: 00..11, never wraps.
    function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        if (taken) begin
            result = (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end else begin
            result = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/btb_assoc_plru.sv
// Tree pseudo-LRU for one set: a bit of 1 steers the victim towards the upper half of its subtree.
// Supports 1, 2 or 4 ways; with a single way the victim is always way 0.
module btb_assoc_plru
    import btb_assoc_pkg::*;
#(
    parameter  int NUM_WAYS = BTB_WAYS,
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int PLRU_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
) (
    input  logic [PLRU_W-1:0] plru_bits,
    input  logic [WAY_W-1:0]  touch_way,
    output logic [WAY_W-1:0]  victim_way,
    output logic [PLRU_W-1:0] next_bits
);

    generate
        if (NUM_WAYS == 4) begin : g_four
            // Bit 0 is the root, bit 1 covers ways 0/1, bit 2 covers ways 2/3.
            assign victim_way = {plru_bits[0], plru_bits[0] ? plru_bits[2] : plru_bits[1]};

            always_comb begin
                next_bits    = plru_bits;
                next_bits[0] = ~touch_way[1];
                if (touch_way[1]) begin
                    next_bits[2] = ~touch_way[0];
                end else begin
                    next_bits[1] = ~touch_way[0];
                end
            end
        end else if (NUM_WAYS == 2) begin : g_two
            assign victim_way = plru_bits;
            assign next_bits  = ~touch_way;
        end else begin : g_one
            assign victim_way = '0;
            assign next_bits  = plru_bits & {PLRU_W{touch_way[0]}} & '0;
        end
    endgenerate

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB with per-entry branch type, 2-bit direction counter and tree-PLRU replacement.
// Valid and PLRU state are cleared by a set-by-set walk after reset or flush; entry storage is never reset.
module btb_assoc
    import btb_assoc_pkg::*;
#(
    parameter int NUM_SETS = BTB_SETS,
    parameter int NUM_WAYS = BTB_WAYS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_lookup,
    input  logic            lookup_en,
    output logic            hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] target_predicted,
    input  logic            update_en,
    input  logic            is_branch_or_jmp,
    input  logic [XLEN-1:0] pc_update,
    input  logic [XLEN-1:0] target_actual,
    input  logic [1:0]      br_type_update,
    input  logic            taken_actual,
    input  logic            flush_req,
    output logic            busy
);

    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = XLEN - IDX_W - 2;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int PLRU_W = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        btb_br_type_e     br_type;
        logic [1:0]       ctr;
    } entry_t;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e             state;
    state_e             state_next;
    logic [IDX_W-1:0]   walk_idx;

    entry_t             entries [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid  [NUM_SETS];
    logic [PLRU_W-1:0]  plru    [NUM_SETS];

    // ---------------- walk FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_INIT;
            walk_idx <= '0;
        end else begin
            state    <= state_next;
            walk_idx <= (state == S_INIT) ? walk_idx + IDX_W'(1) : '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_INIT:  if (walk_idx == IDX_W'(NUM_SETS - 1)) state_next = S_RUN;
            S_RUN:   if (flush_req) state_next = S_INIT;
            default: state_next = S_INIT;
        endcase
    end

    assign busy = !reset || (state == S_INIT);

    // ---------------- lookup ----------------
    logic [XLEN-3:0]  lk_word;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_match;
    logic [WAY_W-1:0] lk_way;
    entry_t           lk_entry;

    assign lk_word = (XLEN-2)'(pc_lookup >> 2);
    assign lk_idx  = lk_word[IDX_W-1:0];
    assign lk_tag  = lk_word[XLEN-3:IDX_W];

    always_comb begin
        lk_match = 1'b0;
        lk_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[lk_idx][w] && (entries[lk_idx][w].tag == lk_tag)) begin
                lk_match = 1'b1;
                lk_way   = WAY_W'(w);
            end
        end
    end

    assign lk_entry         = entries[lk_idx][lk_way];
    assign hit              = lookup_en && !busy && lk_match;
    assign pred_taken       = hit && ((lk_entry.br_type != BR_COND) || lk_entry.ctr[1]);
    assign target_predicted = pred_taken ? lk_entry.target : pc_lookup + XLEN'(4);

    // ---------------- training ----------------
    logic [XLEN-3:0]   up_word;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_match;
    logic [WAY_W-1:0]  up_hit_way;
    logic              up_has_free;
    logic [WAY_W-1:0]  up_free_way;
    logic [WAY_W-1:0]  up_way;
    logic [WAY_W-1:0]  plru_victim;
    logic [PLRU_W-1:0] plru_next;
    logic              up_write;
    entry_t            up_old;
    entry_t            up_entry;

    assign up_word  = (XLEN-2)'(pc_update >> 2);
    assign up_idx   = up_word[IDX_W-1:0];
    assign up_tag   = up_word[XLEN-3:IDX_W];
    assign up_write = reset && (state == S_RUN) && update_en && is_branch_or_jmp;

    // Descending scan so the lowest-numbered free way wins.
    always_comb begin
        up_match    = 1'b0;
        up_hit_way  = '0;
        up_has_free = 1'b0;
        up_free_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid[up_idx][w]) begin
                up_has_free = 1'b1;
                up_free_way = WAY_W'(w);
            end
            if (valid[up_idx][w] && (entries[up_idx][w].tag == up_tag)) begin
                up_match   = 1'b1;
                up_hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        if (up_match) begin
            up_way = up_hit_way;
        end else if (up_has_free) begin
            up_way = up_free_way;
        end else begin
            up_way = plru_victim;
        end
    end

    btb_assoc_plru #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .plru_bits  (plru[up_idx]),
        .touch_way  (up_way),
        .victim_way (plru_victim),
        .next_bits  (plru_next)
    );

    assign up_old = entries[up_idx][up_hit_way];

    always_comb begin
        up_entry         = up_old;
        up_entry.tag     = up_tag;
        up_entry.target  = target_actual;
        up_entry.br_type = btb_br_type_e'(br_type_update);
        up_entry.ctr     = up_match ? ctr_train(up_old.ctr, taken_actual)
                                    : (taken_actual ? 2'b10 : 2'b01);
    end

    always_ff @(posedge clk) begin
        if (up_write) begin
            entries[up_idx][up_way] <= up_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            valid[walk_idx] <= '0;
            plru[walk_idx]  <= '0;
        end else if (up_write) begin
            valid[up_idx][up_way] <= 1'b1;
            plru[up_idx]          <= plru_next;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed scenarios with literal expectations plus a random phase,
// all outputs compared every cycle against a table-based model with true-LRU replacement.
module tb_btb_assoc;
    import btb_assoc_pkg::*;

    localparam int SETS = 64;
    localparam int WAYS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_lookup = '0;
    logic        lookup_en = 1'b0;
    logic        hit;
    logic        pred_taken;
    logic [31:0] target_predicted;
    logic        update_en = 1'b0;
    logic        is_branch_or_jmp = 1'b0;
    logic [31:0] pc_update = '0;
    logic [31:0] target_actual = '0;
    logic [1:0]  br_type_update = '0;
    logic        taken_actual = 1'b0;
    logic        flush_req = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    btb_assoc #(
        .NUM_SETS (SETS),
        .NUM_WAYS (WAYS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_lookup        (pc_lookup),
        .lookup_en        (lookup_en),
        .hit              (hit),
        .pred_taken       (pred_taken),
        .target_predicted (target_predicted),
        .update_en        (update_en),
        .is_branch_or_jmp (is_branch_or_jmp),
        .pc_update        (pc_update),
        .target_actual    (target_actual),
        .br_type_update   (br_type_update),
        .taken_actual     (taken_actual),
        .flush_req        (flush_req),
        .busy             (busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    int          m_type  [SETS][WAYS];
    int          m_ctr   [SETS][WAYS];
    longint      m_stamp [SETS][WAYS];
    longint      m_time = 0;
    int          m_walk = 0;

    function automatic int m_set(input logic [31:0] pc);
        return int'((pc / 4) % SETS);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return pc / (4 * SETS);
    endfunction

    function automatic int m_find(input logic [31:0] pc);
        int s = m_set(pc);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == m_tagof(pc)) return w;
        return -1;
    endfunction

    function automatic void m_invalidate();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_stamp[s][w] = 0;
            end
    endfunction

    function automatic void m_train(input logic [31:0] pc, input logic [31:0] tgt,
                                    input int ty, input bit tk);
        int s = m_set(pc);
        int w = m_find(pc);
        if (w >= 0) begin
            m_ctr[s][w] = tk ? ((m_ctr[s][w] < 3) ? m_ctr[s][w] + 1 : 3)
                             : ((m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0);
        end else begin
            for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
            if (w < 0) begin
                w = 0;
                for (int i = 1; i < WAYS; i++) if (m_stamp[s][i] < m_stamp[s][w]) w = i;
            end
            m_valid[s][w] = 1'b1;
            m_tag[s][w]   = m_tagof(pc);
            m_ctr[s][w]   = tk ? 2 : 1;
        end
        m_tgt[s][w]  = tgt;
        m_type[s][w] = ty;
        m_time++;
        m_stamp[s][w] = m_time;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_walk = SETS;
            m_invalidate();
        end else if (m_walk > 0) begin
            m_walk--;
        end else begin
            if (update_en && is_branch_or_jmp)
                m_train(pc_update, target_actual, int'(br_type_update), taken_actual);
            if (flush_req) begin
                m_walk = SETS;
                m_invalidate();
            end
        end
    end

    // Every cycle: outputs against the model.
    always @(negedge clk) begin
        bit          e_busy;
        bit          e_hit;
        bit          e_pt;
        logic [31:0] e_tgt;
        int          w;
        e_busy = !reset || (m_walk > 0);
        w      = m_find(pc_lookup);
        e_hit  = lookup_en && !e_busy && (w >= 0);
        e_pt   = e_hit && (m_type[m_set(pc_lookup)][w] != 0 || m_ctr[m_set(pc_lookup)][w] >= 2);
        e_tgt  = e_pt ? m_tgt[m_set(pc_lookup)][w] : pc_lookup + 32'd4;
        chk("cyc_busy", 32'(busy), 32'(e_busy));
        chk("cyc_hit", 32'(hit), 32'(e_hit));
        chk("cyc_pred_taken", 32'(pred_taken), 32'(e_pt));
        chk("cyc_target", target_predicted, e_tgt);
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_update(input logic [31:0] pc, input logic [31:0] tgt,
                              input logic [1:0] ty, input logic tk);
        update_en        = 1'b1;
        is_branch_or_jmp = 1'b1;
        pc_update        = pc;
        target_actual    = tgt;
        br_type_update   = ty;
        taken_actual     = tk;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [1:0] ty, input logic tk);
        set_update(pc, tgt, ty, tk);
        next_cycle();
        update_en        = 1'b0;
        is_branch_or_jmp = 1'b0;
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic e_hit,
                        input logic e_pt, input logic [31:0] e_tgt);
        lookup_en = 1'b1;
        pc_lookup = pc;
        @(negedge clk);
        chk({name, "_hit"}, 32'(hit), 32'(e_hit));
        chk({name, "_pt"}, 32'(pred_taken), 32'(e_pt));
        chk({name, "_tgt"}, target_predicted, e_tgt);
        next_cycle();
        lookup_en = 1'b0;
    endtask

    task automatic count_busy(input string name, input int exp);
        int n    = 0;
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
            else begin
                n++;
                next_cycle();
            end
        end
        chk(name, 32'(n), 32'(exp));
        next_cycle();
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 2);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        lookup_en = 1'b1;
        pc_lookup = 32'h0000_1000;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_hit", 32'(hit), 32'd0);
        chk("reset_tgt", target_predicted, 32'h0000_1004);
        next_cycle();
        lookup_en = 1'b0;
        reset     = 1'b1;
        count_busy("init_busy_len", 64);

        look("cold_miss", 32'h0000_1234, 1'b0, 1'b0, 32'h0000_1238);
        look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        train(32'h0000_1000, 32'h0000_2000, BR_COND, 1'b1);
        look("cond_taken", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000);
        train(32'h0000_1000, 32'h0000_2000, BR_COND, 1'b0);
        look("ctr_01", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004);
        train(32'h0000_1000, 32'h0000_2000, BR_COND, 1'b0);
        train(32'h0000_1000, 32'h0000_2000, BR_COND, 1'b0);
        train(32'h0000_1000, 32'h0000_2000, BR_COND, 1'b1);
        look("ctr_sat_low", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004);
        train(32'h0000_1000, 32'h0000_2000, BR_COND, 1'b1);
        look("ctr_10", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000);

        train(32'h0000_3004, 32'h0000_3800, BR_JAL, 1'b0);
        train(32'h0000_3004, 32'h0000_3800, BR_JAL, 1'b0);
        look("jal_ctr00", 32'h0000_3004, 1'b1, 1'b1, 32'h0000_3800);

        train(32'h0000_1100, 32'h0000_2100, BR_COND, 1'b1);
        train(32'h0000_1200, 32'h0000_2200, BR_COND, 1'b1);
        look("evict_1000", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);
        look("keep_1100", 32'h0000_1100, 1'b1, 1'b1, 32'h0000_2100);
        look("keep_1200", 32'h0000_1200, 1'b1, 1'b1, 32'h0000_2200);
        train(32'h0000_1100, 32'h0000_2100, BR_COND, 1'b1);
        train(32'h0000_1000, 32'h0000_2000, BR_COND, 1'b1);
        look("evict_1200", 32'h0000_1200, 1'b0, 1'b0, 32'h0000_1204);
        look("back_1000", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000);

        lookup_en = 1'b1;
        pc_lookup = 32'h0000_1100;
        set_update(32'h0000_1100, 32'h0000_5000, BR_COND, 1'b1);
        @(negedge clk);
        chk("war_old_tgt", target_predicted, 32'h0000_2100);
        next_cycle();
        update_en = 1'b0;
        look("war_new_tgt", 32'h0000_1100, 1'b1, 1'b1, 32'h0000_5000);
        lookup_en = 1'b1;
        pc_lookup = 32'h0000_1300;
        set_update(32'h0000_1300, 32'h0000_1A00, BR_JALR, 1'b1);
        @(negedge clk);
        chk("war_old_miss", 32'(hit), 32'd0);
        next_cycle();
        update_en = 1'b0;
        look("war_new_hit", 32'h0000_1300, 1'b1, 1'b1, 32'h0000_1A00);

        flush_req = 1'b1;
        next_cycle();
        flush_req = 1'b0;
        set_update(32'h0000_4000, 32'h0000_4400, BR_JAL, 1'b1);
        repeat (10) next_cycle();
        update_en = 1'b0;
        count_busy("flush_busy_len", 54);
        look("flushed_1100", 32'h0000_1100, 1'b0, 1'b0, 32'h0000_1104);
        look("flushed_3004", 32'h0000_3004, 1'b0, 1'b0, 32'h0000_3008);
        look("dropped_4000", 32'h0000_4000, 1'b0, 1'b0, 32'h0000_4004);

        flush_req = 1'b1;
        next_cycle();
        flush_req = 1'b0;
        repeat (20) next_cycle();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        count_busy("restart_busy_len", 64);

        for (int i = 0; i < 3000; i++) begin
            lookup_en        = ($urandom_range(0, 3) != 0);
            pc_lookup        = rand_pc();
            update_en        = $urandom_range(0, 1) == 1;
            is_branch_or_jmp = ($urandom_range(0, 7) != 0);
            pc_update        = rand_pc();
            target_actual    = $urandom() & 32'hFFFF_FFFC;
            br_type_update   = 2'($urandom_range(0, 3));
            taken_actual     = $urandom_range(0, 1) == 1;
            flush_req        = ($urandom_range(0, 299) == 0);
            next_cycle();
        end
        lookup_en = 1'b0;
        update_en = 1'b0;
        flush_req = 1'b0;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
